counter_n: RTL and testbench
============================

COUNTER_N -- requirements
Module: counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits (>=1).
REQ-002 SHALL have parameter MODULUS, default 8, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 4, enable divide ratio (>=1); used only under COUNTER_N_PRESCALE_EN.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port CNT  input  1  count enable.
REQ-007 SHALL have port UP  input  1  direction, 1 = increment, 0 = decrement.
REQ-008 SHALL have port SAT  input  1  boundary mode, 1 = saturate, 0 = wrap.
REQ-009 SHALL have port LD  input  1  synchronous load strobe.
REQ-010 SHALL have port DIN  input  WIDTH  load value.
REQ-011 SHALL have port CLR_OVF  input  1  clears sticky overflow flag.
REQ-012 SHALL have port OUT  output  WIDTH  registered count value.
REQ-013 SHALL have port TC  output  1  registered terminal-count pulse.
REQ-014 SHALL have port OVF  output  1  registered sticky boundary-event flag.

Function
REQ-015 SHALL apply priority per rising edge: RST > LD > count step > hold.
REQ-016 SHALL, on LD=1, set OUT to DIN when DIN < MODULUS, else to MODULUS-1 (clamp); LD SHALL NOT assert TC or set OVF.
REQ-017 SHALL, on an effective count step with UP=1, set OUT to OUT+1 when OUT < MODULUS-1.
REQ-018 SHALL, on an effective count step with UP=0, set OUT to OUT-1 when OUT > 0.
REQ-019 SHALL, on an up step at MODULUS-1, go to 0 if SAT=0 or hold MODULUS-1 if SAT=1; a down step at 0 goes to MODULUS-1 if SAT=0 or holds 0 if SAT=1.
REQ-020 SHALL treat REQ-019 cases as a boundary event; TC SHALL be 1 for exactly the cycle following the edge of the boundary event, else 0.
REQ-021 SHALL set OVF to 1 on the edge of any boundary event; OVF SHALL clear to 0 on the edge where CLR_OVF=1 and no boundary event occurs; simultaneous event and CLR_OVF SHALL leave OVF=1.
REQ-022 SHALL let an effective count step equal CNT=1 sampled at the edge (latency one edge) when COUNTER_N_PRESCALE_EN is undefined.
REQ-023 SHALL sample UP and SAT on the same edge as the step; changing them between edges SHALL have no other effect.
REQ-024 SHALL compute OUT+1 with internal width WIDTH+1 so MODULUS=2**WIDTH wraps without truncation artefacts.

Reset
REQ-025 SHALL, on RST=1 at a rising edge, set OUT=0, TC=0, OVF=0, prescaler count=0, regardless of all other inputs.
REQ-026 SHALL, on RST deasserting mid-count, resume from OUT=0 with first step on the first edge with RST=0 and an effective step.

Configuration
REQ-027 SHALL, with macro COUNTER_N_PRESCALE_EN defined, instantiate a prescaler counting edges with CNT=1 (0..PRESCALE-1); effective step only on the edge where the prescaler is at PRESCALE-1 and CNT=1, prescaler then wraps to 0; CNT=0 holds the prescaler; LD resets the prescaler to 0.
REQ-028 SHALL, without COUNTER_N_PRESCALE_EN, contain no prescaler logic and ignore PRESCALE.

Structure
REQ-029 SHALL place shared constants (default WIDTH, MODULUS, PRESCALE, direction encoding UP=1/DOWN=0, mode encoding WRAP=0/SAT=1) in package counter_pkg.
REQ-030 SHALL implement the prescaler as sub-module counter_prescaler (ports CLK, RST, CNT, LD, STEP output), instantiated only under COUNTER_N_PRESCALE_EN.

Verification
REQ-031 SHALL cover: WIDTH=3, MODULUS=8, reset, CNT=1, UP=1, SAT=0, 8 edges -> OUT 1,2,...,7,0; TC=1 only in cycle after 8th edge; OVF=1 thereafter.
REQ-032 SHALL cover: MODULUS=6, OUT=0, UP=0, SAT=0, CNT=1, 2 edges -> OUT 5 then 4; TC pulse after first edge; then SAT=1 load 0, down 3 edges -> OUT stays 0, TC pulses each, OVF=1.
REQ-033 SHALL cover: MODULUS=6, LD=1 DIN=7 -> OUT=5, TC=0; LD=1 with CNT=1 DIN=2 -> OUT=2 (load wins).
REQ-034 SHALL cover: OUT=4, RST=1 with CNT=1, LD=1 -> OUT=0, TC=0, OVF=0 next cycle; RST=0 -> next edge OUT=1.
REQ-035 SHALL cover: OVF=1, CLR_OVF=1 coincident with wrap -> OVF stays 1; CLR_OVF=1 alone -> OVF=0.
REQ-036 SHALL cover (COUNTER_N_PRESCALE_EN, PRESCALE=4): CNT=1 for 12 edges from reset -> OUT increments on edges 4, 8, 12 only, reaching 3.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the counter_n slice: default parameter values and the
// encodings of the direction (UP) and boundary-mode (SAT) inputs.
// No ports (package).
// -----------------------------------------------------------------------------
package counter_pkg;

   // Default parameter values used by counter_n and counter_prescaler
   localparam int DEF_WIDTH    = 3;
   localparam int DEF_MODULUS  = 8;
   localparam int DEF_PRESCALE = 4;

   // Direction encoding on the UP input
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } counter_dir_e;

   // Boundary-mode encoding on the SAT input
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } counter_mode_e;

   // True when a (WIDTH, MODULUS, PRESCALE) triple is a legal configuration
   function automatic bit f_params_legal(input int width, input int modulus,
                                         input int prescale);
      return (width >= 1) && (modulus >= 2) && (modulus <= (2 ** width)) &&
             (prescale >= 1);
   endfunction

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides the count enable of counter_n by PRESCALE. An internal count runs
// 0..PRESCALE-1 on edges where CNT=1 and holds when CNT=0. STEP is asserted
// combinationally while CNT=1 and the count sits at PRESCALE-1, so the step
// takes effect on the same edge where the prescaler wraps back to 0.
//
// Ports
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset, clears the prescale count
//   CNT   in   raw count enable
//   LD    in   load strobe of the parent counter, clears the prescale count
//   STEP  out  effective count step for the parent counter
// -----------------------------------------------------------------------------
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic CLK,
   input  logic RST,
   input  logic CNT,
   input  logic LD,
   output logic STEP
);

   // A one-bit counter still works for PRESCALE=1: it is pinned at 0 = TERM
   localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  TERM = PW'(PRESCALE - 1);

   logic [PW-1:0] r_cnt;
   logic          w_term;

   assign w_term = (r_cnt == TERM);
   assign STEP   = CNT & w_term;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt <= '0;
      end else if (LD) begin
         r_cnt <= '0;
      end else if (CNT) begin
         if (w_term) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + PW'(1);
         end
      end
   end

endmodule : counter_prescaler

// File: rtl/counter_n.sv
// -----------------------------------------------------------------------------
// counter_n
// Modulo-MODULUS up/down counter with synchronous load, wrap or saturate at
// the boundaries, a one-cycle terminal-count pulse and a sticky boundary flag.
// Priority per rising edge: RST > LD > count step > hold.
//
// Parameters
//   WIDTH     counter width in bits (>=1)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   PRESCALE  enable divide ratio (>=1); only used with COUNTER_N_PRESCALE_EN
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   CNT      in   count enable
//   UP       in   direction, 1 = increment, 0 = decrement
//   SAT      in   boundary mode, 1 = saturate, 0 = wrap
//   LD       in   synchronous load strobe
//   DIN      in   load value (clamped to MODULUS-1)
//   CLR_OVF  in   clears the sticky OVF flag
//   OUT      out  registered count
//   TC       out  registered terminal-count pulse (cycle after a boundary event)
//   OVF      out  registered sticky boundary-event flag
//
// Build option
//   COUNTER_N_PRESCALE_EN  when defined, CNT is divided by PRESCALE through
//                          counter_prescaler; when undefined, every edge with
//                          CNT=1 is a count step and no prescaler exists.
// -----------------------------------------------------------------------------
module counter_n
   import counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = DEF_MODULUS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CNT,
   input  logic             UP,
   input  logic             SAT,
   input  logic             LD,
   input  logic [WIDTH-1:0] DIN,
   input  logic             CLR_OVF,
   output logic [WIDTH-1:0] OUT,
   output logic             TC,
   output logic             OVF
);

   // Top count held one bit wider so MODULUS = 2**WIDTH compares cleanly
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);

   // Elaboration-time guard against an illegal configuration
   if (!f_params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_param_check
      $error("counter_n: illegal WIDTH/MODULUS/PRESCALE combination");
   end

   logic [WIDTH-1:0] r_out;
   logic             r_tc;
   logic             r_ovf;

   logic             w_step;
   logic             w_at_bound;
   logic             w_event;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_ld_val;

   // Load value, clamped into the legal count range
   function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] din);
      if ({1'b0, din} <= MAX_EXT) begin
         return din;
      end
      return MAX_W;
   endfunction

   // True when a step in direction 'up' would cross a boundary
   function automatic logic f_at_bound(input logic [WIDTH-1:0] cur,
                                       input logic up);
      if (up == DIR_UP) begin
         return ({1'b0, cur} == MAX_EXT);
      end
      return (cur == '0);
   endfunction

   // Next count for one step, including wrap/saturate at the boundaries
   function automatic logic [WIDTH-1:0] f_next_count(input logic [WIDTH-1:0] cur,
                                                     input logic up,
                                                     input logic sat);
      logic [WIDTH:0] inc;
      // Increment computed at WIDTH+1 bits; the MAX case never uses it
      inc = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
      if (up == DIR_UP) begin
         if ({1'b0, cur} == MAX_EXT) begin
            return (sat == MODE_SAT) ? cur : '0;
         end
         return inc[WIDTH-1:0];
      end
      if (cur == '0) begin
         return (sat == MODE_SAT) ? '0 : MAX_W;
      end
      return cur - WIDTH'(1);
   endfunction

`ifdef COUNTER_N_PRESCALE_EN
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .CNT  (CNT),
      .LD   (LD),
      .STEP (w_step)
   );
`else
   assign w_step = CNT;
`endif

   assign w_at_bound = f_at_bound(r_out, UP);
   assign w_next     = f_next_count(r_out, UP, SAT);
   assign w_ld_val   = f_clamp_load(DIN);
   // A load pre-empts the step, so it can never raise a boundary event
   assign w_event    = w_step & ~LD & w_at_bound;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out <= '0;
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (LD) begin
            r_out <= w_ld_val;
         end else if (w_step) begin
            r_out <= w_next;
         end
         r_tc <= w_event;
         // A boundary event on the same edge as CLR_OVF keeps the flag set
         if (w_event) begin
            r_ovf <= 1'b1;
         end else if (CLR_OVF) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign OUT = r_out;
   assign TC  = r_tc;
   assign OVF = r_ovf;

endmodule : counter_n

// File: tb/tb_counter_n.sv
// -----------------------------------------------------------------------------
// tb_counter_n
// Directed bench for counter_n. Three instances share the same inputs:
//   u_dut8 : WIDTH=3, MODULUS=8 (full binary range), PRESCALE=1
//   u_dut6 : WIDTH=3, MODULUS=6, PRESCALE=1
//   u_dutp : WIDTH=3, MODULUS=8, PRESCALE=4 (divided enable when
//            COUNTER_N_PRESCALE_EN is defined)
// With PRESCALE=1 a step happens on every CNT=1 edge in either build.
// -----------------------------------------------------------------------------
module tb_counter_n;

   logic       CLK;
   logic       RST;
   logic       CNT;
   logic       UP;
   logic       SAT;
   logic       LD;
   logic [2:0] DIN;
   logic       CLR_OVF;

   logic [2:0] out8, out6, outp;
   logic       tc8, tc6, tcp;
   logic       ovf8, ovf6, ovfp;

   int n_chk;
   int n_err;

   counter_n #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u_dut8 (
      .CLK(CLK), .RST(RST), .CNT(CNT), .UP(UP), .SAT(SAT), .LD(LD),
      .DIN(DIN), .CLR_OVF(CLR_OVF), .OUT(out8), .TC(tc8), .OVF(ovf8)
   );

   counter_n #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) u_dut6 (
      .CLK(CLK), .RST(RST), .CNT(CNT), .UP(UP), .SAT(SAT), .LD(LD),
      .DIN(DIN), .CLR_OVF(CLR_OVF), .OUT(out6), .TC(tc6), .OVF(ovf6)
   );

   counter_n #(.WIDTH(3), .MODULUS(8), .PRESCALE(4)) u_dutp (
      .CLK(CLK), .RST(RST), .CNT(CNT), .UP(UP), .SAT(SAT), .LD(LD),
      .DIN(DIN), .CLR_OVF(CLR_OVF), .OUT(outp), .TC(tcp), .OVF(ovfp)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One rising edge, then settle before sampling outputs
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input logic rst, input logic cnt, input logic up,
                         input logic sat, input logic ld, input logic [2:0] din,
                         input logic clr);
      RST = rst; CNT = cnt; UP = up; SAT = sat; LD = ld; DIN = din; CLR_OVF = clr;
   endtask

   task automatic do_reset();
      set_in(1, 0, 1, 0, 0, 3'd0, 0);
      tick();
      set_in(0, 0, 1, 0, 0, 3'd0, 0);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      set_in(1, 0, 1, 0, 0, 3'd0, 0);
      @(negedge CLK);

      // Reset state
      do_reset();
      chk("rst_out8", out8, 0);
      chk("rst_tc8",  tc8,  0);
      chk("rst_ovf8", ovf8, 0);
      chk("rst_out6", out6, 0);

      // Up count wraps through the full 3-bit range
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("up8_out[%0d]", i), out8, i % 8);
         chk($sformatf("up8_tc[%0d]", i),  tc8,  (i == 8) ? 1 : 0);
         chk($sformatf("up8_ovf[%0d]", i), ovf8, (i == 8) ? 1 : 0);
      end
      set_in(0, 0, 1, 0, 0, 3'd0, 0);
      tick();
      chk("hold8_out", out8, 0);
      chk("hold8_tc",  tc8,  0);
      chk("hold8_ovf", ovf8, 1);

      // Up saturate at MODULUS-1
      set_in(0, 0, 1, 1, 1, 3'd7, 0);
      tick();
      chk("ld8_out", out8, 7);
      set_in(0, 1, 1, 1, 0, 3'd0, 0);
      tick();
      chk("sat8_out", out8, 7);
      chk("sat8_tc",  tc8,  1);

      // Down wrap with MODULUS=6
      do_reset();
      set_in(0, 1, 0, 0, 0, 3'd0, 0);
      tick();
      chk("dn6_out1", out6, 5);
      chk("dn6_tc1",  tc6,  1);
      tick();
      chk("dn6_out2", out6, 4);
      chk("dn6_tc2",  tc6,  0);

      // Down saturate at 0
      set_in(0, 0, 0, 1, 1, 3'd0, 0);
      tick();
      chk("ld6_zero_out", out6, 0);
      chk("ld6_zero_tc",  tc6,  0);
      set_in(0, 1, 0, 1, 0, 3'd0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("dsat6_out[%0d]", i), out6, 0);
         chk($sformatf("dsat6_tc[%0d]", i),  tc6,  1);
         chk($sformatf("dsat6_ovf[%0d]", i), ovf6, 1);
      end

      // Load clamp and load-over-count priority
      do_reset();
      set_in(0, 0, 1, 0, 1, 3'd7, 0);
      tick();
      chk("clamp6_out", out6, 5);
      chk("clamp6_tc",  tc6,  0);
      chk("clamp8_out", out8, 7);
      set_in(0, 1, 1, 0, 1, 3'd2, 0);
      tick();
      chk("ldwin6_out", out6, 2);
      chk("ldwin6_tc",  tc6,  0);
      chk("ldwin8_out", out8, 2);
      chk("ldwin6_ovf", ovf6, 0);

      // Reset beats load and count, then counting resumes from 0
      set_in(0, 0, 1, 0, 1, 3'd5, 0);
      tick();
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      tick();
      chk("pre_rst_ovf6", ovf6, 1);
      set_in(0, 0, 1, 0, 1, 3'd4, 0);
      tick();
      chk("pre_rst_out6", out6, 4);
      set_in(1, 1, 1, 0, 1, 3'd3, 1);
      tick();
      chk("rst_pri_out6", out6, 0);
      chk("rst_pri_tc6",  tc6,  0);
      chk("rst_pri_ovf6", ovf6, 0);
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      tick();
      chk("resume_out6", out6, 1);

      // Sticky OVF against CLR_OVF
      set_in(0, 0, 1, 0, 1, 3'd5, 0);
      tick();
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      tick();
      chk("wrap6_out", out6, 0);
      chk("wrap6_ovf", ovf6, 1);
      set_in(0, 0, 1, 0, 1, 3'd5, 0);
      tick();
      chk("ld_keeps_ovf6", ovf6, 1);
      set_in(0, 1, 1, 0, 0, 3'd0, 1);
      tick();
      chk("clr_evt_out6", out6, 0);
      chk("clr_evt_ovf6", ovf6, 1);
      set_in(0, 0, 1, 0, 0, 3'd0, 1);
      tick();
      chk("clr_ovf6",     ovf6, 0);
      chk("clr_tc6",      tc6,  0);
      chk("clr_hold_out6", out6, 0);

`ifdef COUNTER_N_PRESCALE_EN
      // Divided enable: steps only on every fourth CNT edge
      do_reset();
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("pre_out[%0d]", i), outp, i / 4);
      end
      chk("pre_tc", tcp, 0);
`else
      // Undivided enable: every CNT edge is a step
      do_reset();
      set_in(0, 1, 1, 0, 0, 3'd0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("nopre_out[%0d]", i), outp, i);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_counter_n
